queue_event_gen: RTL and testbench

Front-end stage of the queue-management chip: turns the two raw customer push-buttons/sensors (arrival, service) into clean single-cycle UP/DOWN pulses for the occupancy counter. Synchronizes and debounces both inputs, serializes simultaneous events, and gates pulses against the counter's EF/FF flags so the counter never receives an illegal request. Sits directly upstream of the 3-bit occupancy counter and consumes its flags as feedback.

---
 rtl/queue_pkg.sv | 17 +
 rtl/btn_debounce.sv | 48 ++++
 rtl/queue_event_gen.sv | 100 ++++++++++
 tb/tb_queue_event_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// queue_pkg: shared types and constants for the queue-management front end.
//   state_t         issue FSM state (IDLE, HOLD)
//   DEF_DB_CYCLES   default debounce length in clock cycles
//   DEF_HOLD_CYCLES default idle gap after each issued UP/DOWN
//   cnt_w()         width of a counter that must hold values 0..n
package queue_pkg;

   typedef enum logic {IDLE, HOLD} state_t;

   localparam int DEF_DB_CYCLES   = 16;
   localparam int DEF_HOLD_CYCLES = 2;

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes, debounces and edge-detects one raw button.
//   CLK    system clock, rising edge
//   MR_N   asynchronous active-low master reset
//   raw    asynchronous, bouncy, active-high button input
//   press  registered one-cycle pulse on each rising edge of the debounced level
module btn_debounce
   import queue_pkg::*;
#(
   parameter int DB_CYCLES = DEF_DB_CYCLES
) (
   input  logic CLK,
   input  logic MR_N,
   input  logic raw,
   output logic press
);

   localparam int CW = cnt_w(DB_CYCLES);

   logic [1:0]    sync;
   logic          stable;
   logic          stable_d;
   logic [CW-1:0] cnt;

   // The stable level only flips after DB_CYCLES consecutive edges of
   // disagreement; any agreeing sample restarts the count, so short bounces
   // never reach the threshold.
   always_ff @(posedge CLK or negedge MR_N)
      if (!MR_N) begin
         sync     <= '0;
         stable   <= 1'b0;
         stable_d <= 1'b0;
         cnt      <= '0;
         press    <= 1'b0;
      end else begin
         sync     <= {sync[0], raw};
         stable_d <= stable;
         press    <= stable && !stable_d;
         if (sync[1] != stable) begin
            if (cnt == CW'(DB_CYCLES - 1)) begin
               stable <= ~stable;
               cnt    <= '0;
            end else
               cnt <= cnt + 1'b1;
         end else
            cnt <= '0;
      end

endmodule

// File: rtl/queue_event_gen.sv
// queue_event_gen: turns raw arrival/service buttons into clean UP/DOWN
// requests for the occupancy counter, gated by its EF/FF flags.
//   CLK         system clock, rising edge
//   MR_N        asynchronous active-low master reset
//   ARRIVE_RAW  raw arrival button (async, bouncy)
//   SERVE_RAW   raw service button (async, bouncy)
//   EF, FF      counter empty / full flags, sampled only in IDLE decisions
//   UP, DOWN    one-cycle increment / decrement requests
//   REJ_FULL    arrival discarded because the counter is full
//   REJ_EMPTY   service discarded because the counter is empty
//   DROP        event lost because one of the same type was still pending
module queue_event_gen
   import queue_pkg::*;
#(
   parameter int DB_CYCLES   = DEF_DB_CYCLES,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
   input  logic CLK,
   input  logic MR_N,
   input  logic ARRIVE_RAW,
   input  logic SERVE_RAW,
   input  logic EF,
   input  logic FF,
   output logic UP,
   output logic DOWN,
   output logic REJ_FULL,
   output logic REJ_EMPTY,
   output logic DROP
);

   localparam int HW = cnt_w(HOLD_CYCLES);

   state_t        state, state_nx;
   logic [HW-1:0] hcnt, hcnt_nx;
   logic          arr_ev, srv_ev;
   logic          arr_p, srv_p;
   logic          clr_a, clr_s;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_arr (
      .CLK   (CLK),
      .MR_N  (MR_N),
      .raw   (ARRIVE_RAW),
      .press (arr_ev)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_srv (
      .CLK   (CLK),
      .MR_N  (MR_N),
      .raw   (SERVE_RAW),
      .press (srv_ev)
   );

   // A pending bit is consumed whenever IDLE decides on it, whether the
   // decision is an issue or a reject; arrival wins over service.
   always_comb begin
      clr_a    = (state == IDLE) && arr_p;
      clr_s    = (state == IDLE) && !arr_p && srv_p;
      state_nx = state;
      hcnt_nx  = hcnt;
      if (state == IDLE) begin
         if ((clr_a && !FF) || (clr_s && !EF)) begin
            state_nx = HOLD;
            hcnt_nx  = '0;
         end
      end else if (hcnt == HW'(HOLD_CYCLES - 1))
         state_nx = IDLE;
      else
         hcnt_nx = hcnt + 1'b1;
   end

   always_ff @(posedge CLK or negedge MR_N)
      if (!MR_N) begin
         state     <= IDLE;
         hcnt      <= '0;
         arr_p     <= 1'b0;
         srv_p     <= 1'b0;
         UP        <= 1'b0;
         DOWN      <= 1'b0;
         REJ_FULL  <= 1'b0;
         REJ_EMPTY <= 1'b0;
         DROP      <= 1'b0;
      end else begin
         state     <= state_nx;
         hcnt      <= hcnt_nx;
         arr_p     <= (arr_p && !clr_a) || arr_ev;
         srv_p     <= (srv_p && !clr_s) || srv_ev;
         UP        <= clr_a && !FF;
         DOWN      <= clr_s && !EF;
         REJ_FULL  <= clr_a && FF;
         REJ_EMPTY <= clr_s && EF;
         // An event landing on a bit that is being consumed this cycle simply
         // re-arms it; only an uncleared pending bit loses the new event.
         DROP      <= (arr_ev && arr_p && !clr_a) || (srv_ev && srv_p && !clr_s);
      end

   a_updn_excl: assert property (@(posedge CLK) disable iff (!MR_N) !(UP && DOWN));
   a_up_single: assert property (@(posedge CLK) disable iff (!MR_N) UP |=> !UP);
   a_dn_single: assert property (@(posedge CLK) disable iff (!MR_N) DOWN |=> !DOWN);

endmodule

// File: tb/tb_queue_event_gen.sv
// tb_queue_event_gen: scoreboard bench for queue_event_gen (DB_CYCLES=4);
// unit 0 uses HOLD_CYCLES=2, unit 1 uses HOLD_CYCLES=20 for long-HOLD cases.
module tb_queue_event_gen;

   localparam logic [4:0] UPV = 5'b10000;
   localparam logic [4:0] DNV = 5'b01000;
   localparam logic [4:0] RFV = 5'b00100;
   localparam logic [4:0] REV = 5'b00010;
   localparam logic [4:0] DRV = 5'b00001;

   typedef struct {
      int         unit;
      int         cyc;
      logic [4:0] val;
      string      tag;
   } exp_t;

   logic CLK = 1'b0;
   logic mr_a = 1'b1, mr_b = 1'b1;
   logic arr_a = 1'b0, srv_a = 1'b0, arr_b = 1'b0, srv_b = 1'b0;
   logic EF = 1'b1, FF = 1'b0;
   logic up_a, dn_a, rf_a, re_a, dr_a;
   logic up_b, dn_b, rf_b, re_b, dr_b;
   logic [4:0] out_a, out_b;
   int edge_n = 0;
   int errors = 0;
   int checks = 0;
   exp_t sb[$];

   assign out_a = {up_a, dn_a, rf_a, re_a, dr_a};
   assign out_b = {up_b, dn_b, rf_b, re_b, dr_b};

   always #5 CLK = ~CLK;

   queue_event_gen #(.DB_CYCLES(4), .HOLD_CYCLES(2)) dut_a (
      .CLK(CLK), .MR_N(mr_a), .ARRIVE_RAW(arr_a), .SERVE_RAW(srv_a), .EF(EF), .FF(FF),
      .UP(up_a), .DOWN(dn_a), .REJ_FULL(rf_a), .REJ_EMPTY(re_a), .DROP(dr_a)
   );

   queue_event_gen #(.DB_CYCLES(4), .HOLD_CYCLES(20)) dut_b (
      .CLK(CLK), .MR_N(mr_b), .ARRIVE_RAW(arr_b), .SERVE_RAW(srv_b), .EF(EF), .FF(FF),
      .UP(up_b), .DOWN(dn_b), .REJ_FULL(rf_b), .REJ_EMPTY(re_b), .DROP(dr_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic want_ev(input int u, input int c, input logic [4:0] v, input string t);
      exp_t x;
      x.unit = u;
      x.cyc  = c;
      x.val  = v;
      x.tag  = t;
      sb.push_back(x);
   endtask

   // Called at a falling edge; returns at the falling edge just before edge e,
   // so anything driven next is first sampled by edge e.
   task automatic at(input int e);
      while (edge_n < e - 1) @(negedge CLK);
   endtask

   // Every cycle, each unit's outputs must equal the scheduled pulse for that
   // edge, or all zeros if nothing is scheduled.
   initial forever begin
      @(posedge CLK);
      edge_n++;
      #2;
      for (int u = 0; u < 2; u++) begin
         logic [4:0] want;
         string      tag;
         want = 5'b0;
         tag  = $sformatf("quiet%0d@%0d", u, edge_n);
         for (int i = 0; i < sb.size(); i++)
            if (sb[i].unit == u && sb[i].cyc == edge_n) begin
               want = sb[i].val;
               tag  = sb[i].tag;
               sb.delete(i);
               break;
            end
         chk(tag, u ? out_b : out_a, want);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int e;
      #1 mr_a = 1'b0;
      mr_b = 1'b0;
      @(negedge CLK);
      chk("rst_out_a", out_a, 0);
      chk("rst_out_b", out_b, 0);
      at(3);
      mr_a = 1'b1;
      mr_b = 1'b1;
      at(53);
      chk("idle_50", {out_a, out_b}, 0);

      e = edge_n + 1;
      arr_a = 1'b1;
      want_ev(0, e + 8, UPV, "up_latency");
      at(e + 10);
      arr_a = 1'b0;
      at(e + 30);

      e = edge_n + 1;
      arr_a = 1'b1;
      at(e + 3);
      arr_a = 1'b0;
      at(e + 20);
      e = edge_n + 1;
      arr_a = 1'b1;
      want_ev(0, e + 8, UPV, "up_after_glitch");
      at(e + 6);
      arr_a = 1'b0;
      at(e + 25);

      EF = 1'b0;
      e = edge_n + 1;
      arr_a = 1'b1;
      srv_a = 1'b1;
      want_ev(0, e + 8, UPV, "sim_up");
      want_ev(0, e + 11, DNV, "sim_down");
      at(e + 6);
      arr_a = 1'b0;
      srv_a = 1'b0;
      at(e + 30);

      EF = 1'b1;
      e = edge_n + 1;
      srv_a = 1'b1;
      want_ev(0, e + 8, REV, "rej_empty");
      at(e + 6);
      srv_a = 1'b0;
      at(e + 25);

      EF = 1'b0;
      FF = 1'b1;
      e = edge_n + 1;
      arr_a = 1'b1;
      want_ev(0, e + 8, RFV, "rej_full");
      at(e + 6);
      arr_a = 1'b0;
      at(e + 25);

      EF = 1'b1;
      e = edge_n + 1;
      arr_a = 1'b1;
      srv_a = 1'b1;
      want_ev(0, e + 8, RFV, "rej_both_full");
      want_ev(0, e + 9, REV, "rej_both_empty");
      at(e + 6);
      arr_a = 1'b0;
      srv_a = 1'b0;
      at(e + 25);
      EF = 1'b0;
      FF = 1'b0;

      e = edge_n + 1;
      srv_b = 1'b1;
      want_ev(1, e + 8, DNV, "b_down");
      want_ev(1, e + 23, DRV, "b_drop");
      want_ev(1, e + 29, UPV, "b_up_after_hold");
      at(e + 2);
      arr_b = 1'b1;
      at(e + 6);
      srv_b = 1'b0;
      at(e + 8);
      arr_b = 1'b0;
      at(e + 16);
      arr_b = 1'b1;
      at(e + 22);
      arr_b = 1'b0;
      at(e + 60);

      e = edge_n + 1;
      arr_b = 1'b1;
      srv_b = 1'b1;
      want_ev(1, e + 8, UPV, "b_up_prerst");
      at(e + 6);
      arr_b = 1'b0;
      srv_b = 1'b0;
      at(e + 9);
      mr_b = 1'b0;
      #1;
      chk("rst_mid_hold", out_b, 0);
      at(e + 11);
      mr_b = 1'b1;
      at(e + 50);

      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
